// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared types and screen constants for the player sprite
//                motion logic. Holds the motion state encoding, the default
//                screen bounds and the frame tick line.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  // Vertical motion state. The encoding is visible on the mstate port.
  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } mstate_t;

  // Default screen bounds in display-counter coordinates
  localparam int X_MIN_DEF   = 150;
  localparam int X_MAX_DEF   = 775;
  localparam int Y_CEIL_DEF  = 40;
  localparam int Y_FLOOR_DEF = 450;

  // vCount of the first vertical blanking line
  localparam int TICK_LINE   = 516;

endpackage
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_gen
//  Description : Produces a registered one-clock pulse once per frame, one
//                clock after the display counters sit at (0, TICK_LINE).
//  Ports       : clk          in  1   pixel clock
//                rst          in  1   asynchronous active-high reset
//                hcount_i     in  10  display horizontal counter
//                vcount_i     in  10  display vertical counter
//                frame_tick_o out 1   one-clock frame pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_tick_gen #(
  parameter int TICK_LINE = 516
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hcount_i,
  input  logic [9:0] vcount_i,
  output logic       frame_tick_o
);

  localparam logic [9:0] c_tick_line = 10'(TICK_LINE);

  logic frame_tick_q;
  logic frame_tick_d;

  assign frame_tick_d = (hcount_i == 10'd0) && (vcount_i == c_tick_line);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= frame_tick_d;
    end
  end

  assign frame_tick_o = frame_tick_q;

endmodule
`default_nettype wire

// File: rtl/player_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : player_motion_ctrl
//  Description : Per-frame motion sequencer for the player sprite: walk,
//                jump, gravity and floor/ceiling/wall clamping. Position is
//                updated once per frame during vertical blanking.
//  Ports       : clk       in  1   pixel clock
//                rst       in  1   asynchronous active-high reset
//                hCount    in  10  display horizontal counter
//                vCount    in  10  display vertical counter
//                left      in  1   walk left (level)
//                right     in  1   walk right (level)
//                jump      in  1   jump button (rising edge acts)
//                xpos      out 10  sprite x centre
//                ypos      out 10  sprite y centre
//                airborne  out 1   high while rising or falling
//                facing    out 1   0 right, 1 left
//                mstate    out 2   GROUND=0, RISE=1, FALL=2
//  Build macro : PLAYER_DOUBLE_JUMP_EN - accept one extra jump while airborne
//  Revision    : 1.0 - initial release
// ============================================================================
module player_motion_ctrl
  import game_pkg::*;
#(
  parameter int X_INIT    = 450,
  parameter int Y_FLOOR   = Y_FLOOR_DEF,
  parameter int Y_CEIL    = Y_CEIL_DEF,
  parameter int X_MIN     = X_MIN_DEF,
  parameter int X_MAX     = X_MAX_DEF,
  parameter int WALK_STEP = 2,
  parameter int JUMP_VEL  = 12,
  parameter int GRAVITY   = 1,
  parameter int VMAX      = 15,
  parameter int TICK_LINE = game_pkg::TICK_LINE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       left,
  input  logic       right,
  input  logic       jump,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       airborne,
  output logic       facing,
  output logic [1:0] mstate
);

  localparam logic        [9:0]  c_x_init   = 10'(X_INIT);
  localparam logic        [9:0]  c_y_floor  = 10'(Y_FLOOR);
  localparam logic        [9:0]  c_y_ceil   = 10'(Y_CEIL);
  localparam logic        [9:0]  c_x_min    = 10'(X_MIN);
  localparam logic        [9:0]  c_x_max    = 10'(X_MAX);
  localparam logic signed [10:0] c_y_floor_s = 11'(Y_FLOOR);
  localparam logic signed [10:0] c_y_ceil_s  = 11'(Y_CEIL);
  localparam logic signed [10:0] c_x_min_s   = 11'(X_MIN);
  localparam logic        [10:0] c_x_max_u   = 11'(X_MAX);
  localparam logic        [10:0] c_step_u    = 11'(WALK_STEP);
  localparam logic signed [10:0] c_step_s    = 11'(WALK_STEP);
  localparam logic        [5:0]  c_jump_vel = 6'(JUMP_VEL);
  localparam logic        [6:0]  c_grav_u   = 7'(GRAVITY);
  localparam logic signed [6:0]  c_grav_s   = 7'(GRAVITY);
  localparam logic        [6:0]  c_vmax7    = 7'(VMAX);
  localparam logic        [5:0]  c_vmax     = 6'(VMAX);

  logic w_frame_tick;

  frame_tick_gen #(
    .TICK_LINE(TICK_LINE)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .hcount_i    (hCount),
    .vcount_i    (vCount),
    .frame_tick_o(w_frame_tick)
  );

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  mstate_t    state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [5:0] vy_q, vy_d;
  logic       facing_q, facing_d;
  logic       airborne_q, airborne_d;
  logic       jump_prev_q, jump_prev_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic       dj_used_q, dj_used_d;
`endif

  // --------------------------------------------------------------------------
  // Datapath helpers. Vertical sums are 11-bit signed so y - vy never wraps.
  // --------------------------------------------------------------------------
  logic signed [10:0] w_y_s, w_vy_s, w_y_up, w_y_dn;
  logic signed [6:0]  w_vy_dec;
  logic        [6:0]  w_vy_inc;
  logic        [5:0]  w_vy_inc_sat;
  logic        [10:0] w_x_plus;
  logic signed [10:0] w_x_minus;
  logic               w_jump_edge;

  assign w_y_s        = signed'({1'b0, y_q});
  assign w_vy_s       = signed'({5'b0, vy_q});
  assign w_y_up       = w_y_s - w_vy_s;
  assign w_y_dn       = w_y_s + w_vy_s;
  assign w_vy_dec     = signed'({1'b0, vy_q}) - c_grav_s;
  assign w_vy_inc     = {1'b0, vy_q} + c_grav_u;
  assign w_vy_inc_sat = (w_vy_inc > c_vmax7) ? c_vmax : w_vy_inc[5:0];
  assign w_x_plus     = {1'b0, x_q} + c_step_u;
  assign w_x_minus    = signed'({1'b0, x_q}) - c_step_s;
  assign w_jump_edge  = jump & ~jump_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= GROUND;
      x_q         <= c_x_init;
      y_q         <= c_y_floor;
      vy_q        <= 6'd0;
      facing_q    <= 1'b0;
      airborne_q  <= 1'b0;
      // Held high so a jump button held through reset does not launch
      jump_prev_q <= 1'b1;
`ifdef PLAYER_DOUBLE_JUMP_EN
      dj_used_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vy_q        <= vy_d;
      facing_q    <= facing_d;
      airborne_q  <= airborne_d;
      jump_prev_q <= jump_prev_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
      dj_used_q   <= dj_used_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: everything holds except on the frame tick
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    vy_d        = vy_q;
    facing_d    = facing_q;
    jump_prev_d = jump_prev_q;
`ifdef PLAYER_DOUBLE_JUMP_EN
    dj_used_d   = dj_used_q;
`endif

    if (w_frame_tick) begin
      jump_prev_d = jump;

      // Horizontal walk, independent of vertical state
      if (right && !left) begin
        x_d      = (w_x_plus > c_x_max_u) ? c_x_max : w_x_plus[9:0];
        facing_d = 1'b0;
      end else if (left && !right) begin
        x_d      = (w_x_minus < c_x_min_s) ? c_x_min : w_x_minus[9:0];
        facing_d = 1'b1;
      end

      unique case (state_q)
        GROUND: begin
          if (w_jump_edge) begin
            state_d = RISE;
            vy_d    = c_jump_vel;
          end
        end
        RISE, FALL: begin
`ifdef PLAYER_DOUBLE_JUMP_EN
          if (w_jump_edge && !dj_used_q) begin
            // Mid-air relaunch replaces this tick's vertical step
            state_d   = RISE;
            vy_d      = c_jump_vel;
            dj_used_d = 1'b1;
          end else
`endif
          if (state_q == RISE) begin
            if (w_y_up <= c_y_ceil_s) begin
              y_d     = c_y_ceil;
              vy_d    = 6'd0;
              state_d = FALL;
            end else begin
              y_d = w_y_up[9:0];
              if (w_vy_dec <= 7'sd0) begin
                vy_d    = 6'd0;
                state_d = FALL;
              end else begin
                vy_d = w_vy_dec[5:0];
              end
            end
          end else begin
            if (w_y_dn >= c_y_floor_s) begin
              y_d     = c_y_floor;
              vy_d    = 6'd0;
              state_d = GROUND;
`ifdef PLAYER_DOUBLE_JUMP_EN
              dj_used_d = 1'b0;
`endif
            end else begin
              y_d  = w_y_dn[9:0];
              vy_d = w_vy_inc_sat;
            end
          end
        end
        default: begin
          state_d = GROUND;
          vy_d    = 6'd0;
        end
      endcase
    end

    airborne_d = (state_d != GROUND);
  end

  assign xpos     = x_q;
  assign ypos     = y_q;
  assign airborne = airborne_q;
  assign facing   = facing_q;
  assign mstate   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_player_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_player_motion_ctrl
//  Description : Self-checking bench for player_motion_ctrl. Two instances
//                (default ceiling and a low ceiling of 400) share stimulus and
//                are compared every frame against a behavioural model.
//                Frames are compressed to 8 clocks with the counters driven
//                directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_player_motion_ctrl;

  localparam int c_tick_line = 516;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hCount, vCount;
  logic       left, right, jump;

  logic [9:0] xpos0, ypos0, xpos1, ypos1;
  logic       air0, air1, fac0, fac1;
  logic [1:0] st0, st1;

  int total = 0;
  int bad   = 0;
  int tick_cnt = 0;

  // Model state, index 0 = default ceiling, index 1 = ceiling 400
  int mx[2], my[2], mvy[2], mst[2], mfac[2], mjp[2], mdj[2];
  int mceil[2] = '{40, 400};

  always #5 clk = ~clk;

  player_motion_ctrl u_dut (
    .clk(clk), .rst(rst), .hCount(hCount), .vCount(vCount),
    .left(left), .right(right), .jump(jump),
    .xpos(xpos0), .ypos(ypos0), .airborne(air0), .facing(fac0), .mstate(st0)
  );

  player_motion_ctrl #(.Y_CEIL(400)) u_dut_c (
    .clk(clk), .rst(rst), .hCount(hCount), .vCount(vCount),
    .left(left), .right(right), .jump(jump),
    .xpos(xpos1), .ypos(ypos1), .airborne(air1), .facing(fac1), .mstate(st1)
  );

  always @(negedge clk) begin
    if (u_dut.u_tick.frame_tick_q) tick_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mx[k] = 450; my[k] = 450; mvy[k] = 0; mst[k] = 0;
      mfac[k] = 0; mjp[k] = 1; mdj[k] = 0;
    end
  endtask

  // One frame of the game rules for model instance k
  task automatic model_step(input int k, input logic l, input logic r, input logic j);
    bit edge_j;
    bit dj_ok;
    edge_j = j && (mjp[k] == 0);
    mjp[k] = j;
    if (r && !l) begin
      mx[k] = (mx[k] + 2 > 775) ? 775 : mx[k] + 2;
      mfac[k] = 0;
    end else if (l && !r) begin
      mx[k] = (mx[k] - 2 < 150) ? 150 : mx[k] - 2;
      mfac[k] = 1;
    end
`ifdef PLAYER_DOUBLE_JUMP_EN
    dj_ok = 1'b1;
`else
    dj_ok = 1'b0;
`endif
    if (mst[k] == 0) begin
      if (edge_j) begin mst[k] = 1; mvy[k] = 12; end
    end else if (dj_ok && edge_j && mdj[k] == 0) begin
      mst[k] = 1; mvy[k] = 12; mdj[k] = 1;
    end else if (mst[k] == 1) begin
      if (my[k] - mvy[k] <= mceil[k]) begin
        my[k] = mceil[k]; mvy[k] = 0; mst[k] = 2;
      end else begin
        my[k] -= mvy[k];
        mvy[k] -= 1;
        if (mvy[k] <= 0) begin mvy[k] = 0; mst[k] = 2; end
      end
    end else begin
      if (my[k] + mvy[k] >= 450) begin
        my[k] = 450; mvy[k] = 0; mst[k] = 0; mdj[k] = 0;
      end else begin
        my[k] += mvy[k];
        mvy[k] = (mvy[k] + 1 > 15) ? 15 : mvy[k] + 1;
      end
    end
  endtask

  task automatic check_all();
    check_val("x0",   xpos0, mx[0]);
    check_val("y0",   ypos0, my[0]);
    check_val("st0",  st0,   mst[0]);
    check_val("air0", air0,  (mst[0] != 0));
    check_val("fac0", fac0,  mfac[0]);
    check_val("x1",   xpos1, mx[1]);
    check_val("y1",   ypos1, my[1]);
    check_val("st1",  st1,   mst[1]);
    check_val("air1", air1,  (mst[1] != 0));
    check_val("fac1", fac1,  mfac[1]);
  endtask

  task automatic idle_counters();
    hCount = 10'($urandom_range(0, 799));
    vCount = 10'($urandom_range(0, c_tick_line - 1));
  endtask

  // One compressed frame: match cycle, tick cycle, update, then idle cycles
  task automatic run_frame(input logic l, input logic r, input logic j);
    @(posedge clk); #1;
    hCount = 10'd0; vCount = 10'(c_tick_line);
    left = l; right = r; jump = j;
    tick_cnt = 0;
    @(posedge clk); #1;
    idle_counters();
    // Match sampled, tick now high: outputs must still hold
    check_val("hold_x", xpos0, mx[0]);
    check_val("hold_y", ypos0, my[0]);
    @(posedge clk); #1;
    model_step(0, l, r, j);
    model_step(1, l, r, j);
    check_all();
    repeat (5) begin
      @(posedge clk); #1;
      idle_counters();
    end
    check_val("ticks", tick_cnt, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    model_reset();
    // Asynchronous: reset values visible before any clock edge
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int air_frames;

  initial begin
    rst = 1'b1; left = 0; right = 0; jump = 0;
    hCount = 10'd5; vCount = 10'd0;
    model_reset();
    #23;
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle frames at reset position
    repeat (5) run_frame(0, 0, 0);
    check_val("idle_x", xpos0, 450);
    check_val("idle_y", ypos0, 450);

    // Full jump with default parameters; low-ceiling instance clamps
    air_frames = 0;
    for (int i = 0; i < 26; i++) begin
      run_frame(0, 0, (i == 0));
      if (air0) air_frames++;
      if (i == 5) begin
        check_val("ceil_y", ypos1, 400);
        check_val("ceil_st", st1, 2);
      end
      if (i == 12) begin
        check_val("peak_y", ypos0, 372);
        check_val("peak_st", st0, 2);
      end
    end
    check_val("land_y", ypos0, 450);
    check_val("land_st", st0, 0);
    check_val("air_frames", air_frames, 25);
    check_val("ceil_land", ypos1, 450);

    // Walk right into the wall, then both buttons, then left
    repeat (170) run_frame(0, 1, 0);
    check_val("wall_x", xpos0, 775);
    check_val("wall_fac", fac0, 0);
    repeat (4) run_frame(1, 1, 0);
    check_val("both_x", xpos0, 775);
    check_val("both_fac", fac0, 0);
    run_frame(1, 0, 0);
    check_val("left_x", xpos0, 773);

    // Jump held through reset release must not launch
    jump = 1'b1;
    do_reset();
    repeat (3) run_frame(0, 0, 1);
    check_val("held_st", st0, 0);
    run_frame(0, 0, 0);
    run_frame(1, 0, 1);
    repeat (11) run_frame(0, 0, 0);
    do_reset();
    check_val("rst_x", xpos0, 450);
    check_val("rst_y", ypos0, 450);
    check_val("rst_st", st0, 0);

    // Repeated jump edges while airborne
    run_frame(0, 0, 1);
    run_frame(0, 0, 0);
    run_frame(0, 0, 0);
    run_frame(0, 0, 1);
    run_frame(0, 0, 0);
    run_frame(0, 0, 0);
    run_frame(0, 0, 1);
    repeat (45) run_frame(0, 0, 0);
    check_val("dj_land", st0, 0);

    // Random play with occasional reset
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        jump = 1'($urandom_range(0, 1));
        do_reset();
      end
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
